// File: rtl/eprisc_bus_pkg.sv
// Shared types and default memory map for the epRISC front-side bus fabric.
package eprisc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } bus_state_t;

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE    = 32'h0000_0100;
  localparam logic [31:0] RAM_BASE    = 32'h0000_0100;
  localparam logic [31:0] RAM_SIZE    = 32'h0000_0100;
  localparam logic [31:0] BUSCTL_BASE = 32'h0000_0200;
  localparam logic [31:0] BUSCTL_SIZE = 32'h0000_0010;

  localparam logic [95:0] DEFAULT_REGION_BASE = {BUSCTL_BASE, RAM_BASE, ROM_BASE};
  localparam logic [95:0] DEFAULT_REGION_SIZE = {BUSCTL_SIZE, RAM_SIZE, ROM_SIZE};

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eprisc_bus_fabric_if.sv
// Core-side and slave-side bus signals of the fabric; slave modport is the fabric's view.
interface eprisc_bus_fabric_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3
);
  logic                         iRequest;
  logic [ADDR_W-1:0]            iAddress;
  logic                         iWrite;
  logic [DATA_W-1:0]            iWriteData;
  logic                         oReady;
  logic                         oError;
  logic [DATA_W-1:0]            oReadData;
  logic [NUM_SLAVES-1:0]        oSlaveSelect;
  logic [ADDR_W-1:0]            oSlaveAddress;
  logic                         oSlaveWrite;
  logic [DATA_W-1:0]            oSlaveWriteData;
  logic [NUM_SLAVES-1:0]        iSlaveReady;
  logic [NUM_SLAVES*DATA_W-1:0] iSlaveReadData;
  logic                         oBusy;

  modport slave (
    input  iRequest, iAddress, iWrite, iWriteData, iSlaveReady, iSlaveReadData,
    output oReady, oError, oReadData, oSlaveSelect, oSlaveAddress, oSlaveWrite,
           oSlaveWriteData, oBusy
  );

  modport master (
    output iRequest, iAddress, iWrite, iWriteData, iSlaveReady, iSlaveReadData,
    input  oReady, oError, oReadData, oSlaveSelect, oSlaveAddress, oSlaveWrite,
           oSlaveWriteData, oBusy
  );
endinterface

// File: rtl/eprisc_region_decoder.sv
// Combinational half-open region decoder; lowest-indexed matching region wins.
module eprisc_region_decoder
  import eprisc_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES  = 3,
  parameter int                           ADDR_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZE = DEFAULT_REGION_SIZE,
  localparam int                          IDX_W       = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  hit_o,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [ADDR_W-1:0]     offset_o
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] size;
  logic [ADDR_W:0]   limit;

  always_comb begin
    hit_o    = 1'b0;
    sel_o    = '0;
    idx_o    = '0;
    offset_o = '0;
    base     = '0;
    size     = '0;
    limit    = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      base  = REGION_BASE[i*ADDR_W +: ADDR_W];
      size  = REGION_SIZE[i*ADDR_W +: ADDR_W];
      // One extra bit keeps base+size from wrapping at the top of the space
      limit = {1'b0, base} + {1'b0, size};
      if (!hit_o && (size != '0) && (addr_i >= base) && ({1'b0, addr_i} < limit)) begin
        hit_o    = 1'b1;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        offset_o = addr_i - base;
      end
    end
  end

endmodule

// File: rtl/eprisc_bus_fabric.sv
// Registered N-channel bus fabric: decode, wait-state sequencing, unmapped/timeout errors.
module eprisc_bus_fabric
  import eprisc_bus_pkg::*;
#(
  parameter int                           ADDR_W      = 32,
  parameter int                           DATA_W      = 32,
  parameter int                           NUM_SLAVES  = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZE = DEFAULT_REGION_SIZE,
  parameter int                           TIMEOUT     = 255,
  parameter logic [DATA_W-1:0]            ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
  input logic                iClock,
  input logic                iReset,
  eprisc_bus_fabric_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bus_state_t            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  busy_q, busy_d;

  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic [IDX_W-1:0]      dec_idx;
  logic [ADDR_W-1:0]     dec_offset;
  logic                  slave_ready;
  logic                  timed_out;
  logic [DATA_W-1:0]     slave_rdata;

  eprisc_region_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decoder (
    .addr_i   (bus.iAddress),
    .hit_o    (dec_hit),
    .sel_o    (dec_sel),
    .idx_o    (dec_idx),
    .offset_o (dec_offset)
  );

  assign slave_ready = |(bus.iSlaveReady & sel_q);
  assign timed_out   = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    slave_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) slave_rdata = bus.iSlaveReadData[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.iRequest) state_d = dec_hit ? ACCESS : DONE;
      ACCESS:  if (slave_ready || timed_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion flags are registered on the DONE transition so oReady/oError/oReadData
  // appear together during the single DONE cycle.
  always_comb begin
    sel_d   = sel_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = '0;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.iRequest) begin
          cnt_d = '0;
          if (dec_hit) begin
            sel_d   = dec_sel;
            idx_d   = dec_idx;
            addr_d  = dec_offset;
            write_d = bus.iWrite;
            wdata_d = bus.iWriteData;
          end else begin
            ready_d = 1'b1;
            error_d = 1'b1;
            rdata_d = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        if (slave_ready) begin
          sel_d   = '0;
          write_d = 1'b0;
          ready_d = 1'b1;
          rdata_d = write_q ? '0 : slave_rdata;
        end else if (timed_out) begin
          sel_d   = '0;
          write_d = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.oReady          = ready_q;
  assign bus.oError          = error_q;
  assign bus.oReadData       = rdata_q;
  assign bus.oSlaveSelect    = sel_q;
  assign bus.oSlaveAddress   = addr_q;
  assign bus.oSlaveWrite     = write_q;
  assign bus.oSlaveWriteData = wdata_q;
  assign bus.oBusy           = busy_q;

endmodule

// File: tb/tb_eprisc_bus_fabric.sv
// Directed bench for eprisc_bus_fabric: default map with TIMEOUT=4, plus an overlapping-map instance.
module tb_eprisc_bus_fabric;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  eprisc_bus_fabric_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) b0 ();
  eprisc_bus_fabric_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) b1 ();

  eprisc_bus_fabric #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(4)
  ) u_main (
    .iClock(clk), .iReset(rst), .bus(b0.slave)
  );

  eprisc_bus_fabric #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3),
    .REGION_BASE({32'h200, 32'h100, 32'h100}),
    .REGION_SIZE({32'h10, 32'h100, 32'h100})
  ) u_ovl (
    .iClock(clk), .iReset(rst), .bus(b1.slave)
  );

  // Drives one transaction on u_main. Slave ready (mask) is raised only in the
  // cycle after edge w (w<0: never); noise is raised every cycle.
  task automatic main_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [2:0] mask, input int w, input logic [2:0] noise,
                          output int lat, output logic err, output logic [31:0] rd,
                          output logic [2:0] sel_or, output int sel_cyc,
                          output logic [31:0] saddr, output logic wr_ok,
                          output logic wd_ok, output logic busy_ok);
    lat = -1; err = 1'b0; rd = '0; sel_or = '0; sel_cyc = 0; saddr = '0;
    wr_ok = 1'b1; wd_ok = 1'b1; busy_ok = 1'b1;
    b0.iRequest = 1'b1; b0.iAddress = addr; b0.iWrite = wr; b0.iWriteData = wd;
    b0.iSlaveReady = noise;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      b0.iAddress    = 32'hDEAD_0000;
      b0.iWriteData  = ~wd;
      b0.iWrite      = ~wr;
      b0.iSlaveReady = noise | ((k == w) ? mask : 3'b000);
      @(negedge clk);
      if (b0.oBusy !== 1'b1) busy_ok = 1'b0;
      if (b0.oSlaveSelect !== 3'b000) begin
        sel_cyc++;
        sel_or |= b0.oSlaveSelect;
        saddr = b0.oSlaveAddress;
        if (b0.oSlaveWrite !== wr) wr_ok = 1'b0;
        if (wr && (b0.oSlaveWriteData !== wd)) wd_ok = 1'b0;
      end
      if (b0.oReady === 1'b1) begin
        lat = k + 1;
        err = b0.oError;
        rd  = b0.oReadData;
      end
    end
    @(posedge clk); #1;
    b0.iRequest = 1'b0; b0.iWrite = 1'b0; b0.iSlaveReady = '0;
  endtask

  int          lat, sel_cyc;
  logic        err, wr_ok, wd_ok, busy_ok;
  logic [31:0] rd, saddr;
  logic [2:0]  sel_or;

  task automatic test_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (b0.oReady !== 1'b0 || b0.oError !== 1'b0 || b0.oBusy !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b exp=000", b0.oReady, b0.oError, b0.oBusy); end
    checks++; if (b0.oSlaveSelect !== 3'b000) begin
      failures++; $display("FAIL reset_select got=%b exp=000", b0.oSlaveSelect); end
    checks++; if (b0.oReadData !== 32'h0 || b0.oSlaveAddress !== 32'h0 || b0.oSlaveWriteData !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", b0.oReadData, b0.oSlaveAddress, b0.oSlaveWriteData); end
    checks++; if (b1.oBusy !== 1'b0 || b1.oReady !== 1'b0) begin
      failures++; $display("FAIL reset_ovl got=%b%b exp=00", b1.oBusy, b1.oReady); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    main_txn(32'h010, 1'b0, 32'h0, 3'b001, 0, 3'b000, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd0_latency got=%0d exp=2", lat); end
    checks++; if (sel_or !== 3'b001 || sel_cyc !== 1) begin
      failures++; $display("FAIL rd0_select got=%b/%0d exp=001/1", sel_or, sel_cyc); end
    checks++; if (saddr !== 32'h010) begin failures++; $display("FAIL rd0_offset got=%h exp=00000010", saddr); end
    checks++; if (rd !== 32'h1234_5678 || err !== 1'b0) begin
      failures++; $display("FAIL rd0_data got=%h err=%b exp=12345678 err=0", rd, err); end
    checks++; if (wr_ok !== 1'b1 || busy_ok !== 1'b1) begin
      failures++; $display("FAIL rd0_write_busy got=%b%b exp=11", wr_ok, busy_ok); end
    @(negedge clk);
    checks++; if (b0.oBusy !== 1'b0 || b0.oReady !== 1'b0) begin
      failures++; $display("FAIL rd0_idle got=%b%b exp=00", b0.oBusy, b0.oReady); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_waits();
    main_txn(32'h105, 1'b1, 32'hCAFE_F00D, 3'b010, 3, 3'b000, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (lat !== 5) begin failures++; $display("FAIL wr_latency got=%0d exp=5", lat); end
    checks++; if (sel_or !== 3'b010 || sel_cyc !== 4) begin
      failures++; $display("FAIL wr_select got=%b/%0d exp=010/4", sel_or, sel_cyc); end
    checks++; if (saddr !== 32'h005) begin failures++; $display("FAIL wr_offset got=%h exp=00000005", saddr); end
    checks++; if (wr_ok !== 1'b1 || wd_ok !== 1'b1) begin
      failures++; $display("FAIL wr_stable got=%b%b exp=11", wr_ok, wd_ok); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL wr_result got=%h err=%b exp=00000000 err=0", rd, err); end
  endtask

  task automatic test_unmapped_back_to_back();
    main_txn(32'h20F, 1'b0, 32'h0, 3'b100, 0, 3'b000, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (sel_or !== 3'b100 || saddr !== 32'h00F) begin
      failures++; $display("FAIL edge_hit got=%b/%h exp=100/0000000f", sel_or, saddr); end
    checks++; if (lat !== 2 || rd !== 32'h3333_3333 || err !== 1'b0) begin
      failures++; $display("FAIL edge_read got=%0d/%h/%b exp=2/33333333/0", lat, rd, err); end
    main_txn(32'h210, 1'b0, 32'h0, 3'b111, 0, 3'b111, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (sel_cyc !== 0 || sel_or !== 3'b000) begin
      failures++; $display("FAIL unmapped_select got=%b/%0d exp=000/0", sel_or, sel_cyc); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL unmapped_latency got=%0d exp=1", lat); end
    checks++; if (err !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL unmapped_result got=%h err=%b exp=ffffffff err=1", rd, err); end
  endtask

  task automatic test_timeout();
    main_txn(32'h150, 1'b0, 32'h0, 3'b010, -1, 3'b101, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (lat !== 6) begin failures++; $display("FAIL to_latency got=%0d exp=6", lat); end
    checks++; if (err !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL to_result got=%h err=%b exp=ffffffff err=1", rd, err); end
    checks++; if (sel_or !== 3'b010 || sel_cyc !== 5 || saddr !== 32'h050) begin
      failures++; $display("FAIL to_select got=%b/%0d/%h exp=010/5/00000050", sel_or, sel_cyc, saddr); end
    main_txn(32'h150, 1'b0, 32'h0, 3'b010, 4, 3'b000, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (lat !== 6 || err !== 1'b0 || rd !== 32'h2222_2222) begin
      failures++; $display("FAIL to_last_ready got=%0d/%b/%h exp=6/0/22222222", lat, err, rd); end
  endtask

  task automatic test_reset_mid();
    b0.iRequest = 1'b1; b0.iAddress = 32'h100; b0.iWrite = 1'b0; b0.iSlaveReady = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (b0.oBusy !== 1'b1 || b0.oSlaveSelect !== 3'b010) begin
      failures++; $display("FAIL rst_mid_pre got=%b/%b exp=1/010", b0.oBusy, b0.oSlaveSelect); end
    rst = 1'b1; #1;
    checks++; if (b0.oSlaveSelect !== 3'b000 || b0.oBusy !== 1'b0 || b0.oReady !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got=%b/%b/%b exp=000/0/0", b0.oSlaveSelect, b0.oBusy, b0.oReady); end
    @(posedge clk); #1; b0.iRequest = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (b0.oBusy !== 1'b0 || b0.oReady !== 1'b0) begin
      failures++; $display("FAIL rst_mid_after got=%b%b exp=00", b0.oBusy, b0.oReady); end
    main_txn(32'h000, 1'b0, 32'h0, 3'b001, 0, 3'b000, lat, err, rd, sel_or, sel_cyc, saddr, wr_ok, wd_ok, busy_ok);
    checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'h1234_5678 || sel_or !== 3'b001 || saddr !== 32'h0) begin
      failures++; $display("FAIL rst_mid_fresh got=%0d/%b/%h/%b/%h exp=2/0/12345678/001/00000000", lat, err, rd, sel_or, saddr); end
  endtask

  task automatic test_overlap();
    int          olat;
    logic [2:0]  osel;
    logic [31:0] oaddr, ord;
    logic        oerr;
    olat = -1; osel = '0; oaddr = '0; ord = '0; oerr = 1'b0;
    b1.iRequest = 1'b1; b1.iAddress = 32'h180; b1.iWrite = 1'b0; b1.iSlaveReady = '0;
    for (int k = 0; k < 20 && olat < 0; k++) begin
      @(posedge clk); #1;
      b1.iSlaveReady = (k < 2) ? 3'b010 : ((k == 2) ? 3'b001 : 3'b000);
      @(negedge clk);
      if (b1.oSlaveSelect !== 3'b000) begin osel |= b1.oSlaveSelect; oaddr = b1.oSlaveAddress; end
      if (b1.oReady === 1'b1) begin olat = k + 1; oerr = b1.oError; ord = b1.oReadData; end
    end
    @(posedge clk); #1; b1.iRequest = 1'b0; b1.iSlaveReady = '0;
    checks++; if (osel !== 3'b001 || oaddr !== 32'h080) begin
      failures++; $display("FAIL ovl_select got=%b/%h exp=001/00000080", osel, oaddr); end
    checks++; if (olat !== 4 || oerr !== 1'b0 || ord !== 32'h5555_AAAA) begin
      failures++; $display("FAIL ovl_result got=%0d/%b/%h exp=4/0/5555aaaa", olat, oerr, ord); end
  endtask

  initial begin
    b0.iRequest = 1'b0; b0.iAddress = '0; b0.iWrite = 1'b0; b0.iWriteData = '0;
    b0.iSlaveReady = '0; b0.iSlaveReadData = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678};
    b1.iRequest = 1'b0; b1.iAddress = '0; b1.iWrite = 1'b0; b1.iWriteData = '0;
    b1.iSlaveReady = '0; b1.iSlaveReadData = {32'h0000_0000, 32'hAAAA_1111, 32'h5555_AAAA};
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_unmapped_back_to_back();
    test_timeout();
    test_reset_mid();
    test_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
